// File: rtl/pre_if_stage_pkg.sv
// Shared constants for the pre-IF (next-PC) stage.
package pre_if_stage_pkg;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC_DEF    = 32'h1c00_0000;
  // Fixed instruction size; the sequential PC steps by this amount.
  localparam logic [31:0] INST_BYTES      = 32'd4;
  // Instruction SRAM is read-only from this stage.
  localparam logic [3:0]  SRAM_WE_ZERO    = 4'b0000;
  localparam logic [31:0] SRAM_WDATA_ZERO = 32'h0000_0000;

  // Force a byte address onto a word boundary for the SRAM port.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pre_if_stage_br_redirect_buf.sv
// Holds a branch redirect that arrived while IF could not accept a new PC,
// so the redirect is not lost across IF stall cycles.
module br_redirect_buf
  import pre_if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        advance_i,
  output logic        br_pend_o,
  output logic [31:0] br_pend_tgt_o
);

  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;

  // Capture on a blocked branch (newest wins), clear once the PC advances.
  always_comb begin
    pend_d = pend_q;
    tgt_d  = tgt_q;
    if (advance_i) begin
      pend_d = 1'b0;
    end else if (br_taken_i) begin
      pend_d = 1'b1;
      tgt_d  = br_target_i;
    end
  end

  // Pending-redirect registers; reset always discards any buffered branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      tgt_q  <= 32'h0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end

  assign br_pend_o     = pend_q;
  assign br_pend_tgt_o = tgt_q;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, picks sequential or redirect next PC and
// drives the synchronous instruction SRAM read so rdata lines up with pc.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allow_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        to_fs_valid,
  output logic [31:0] pc,
  output logic        pc_adef,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] seq_pc, redirect_tgt, nextpc, fetch_addr;
  logic        redirect, advance;
  logic        br_pend;
  logic [31:0] br_pend_tgt;

  br_redirect_buf u_br_buf (
    .clk           (clk),
    .reset         (reset),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .advance_i     (advance),
    .br_pend_o     (br_pend),
    .br_pend_tgt_o (br_pend_tgt)
  );

  // Next-PC select and SRAM address: on an IF stall the held PC is re-read
  // so rdata stays matched to pc, and release needs no bubble.
  always_comb begin
    seq_pc       = pc_q + INST_BYTES;
    redirect     = br_taken | br_pend;
    redirect_tgt = br_taken ? br_target : br_pend_tgt;
    nextpc       = redirect ? redirect_tgt : seq_pc;
    advance      = to_fs_valid & fs_allow_in;
    pc_d         = advance ? nextpc : pc_q;
    fetch_addr   = reset ? RESET_PC : pc_d;
  end

  // Fetch PC register; starts one word early so the first advance lands on RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC - INST_BYTES;
    else       pc_q <= pc_d;
  end

  // The stage is always ready to go outside reset.
  assign to_fs_valid     = ~reset;
  assign inst_sram_en    = ~reset;
  assign inst_sram_we    = SRAM_WE_ZERO;
  assign inst_sram_wdata = SRAM_WDATA_ZERO;
  assign inst_sram_addr  = word_align(fetch_addr);
  assign pc              = pc_q;
  // Misaligned fetch is still issued aligned; downstream raises the fault.
  assign pc_adef         = |pc_q[1:0];

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed checks for the pre-IF stage: reset, sequential fetch, stalls,
// live and buffered redirects, reset over a pending redirect, misalign, wrap.
module tb_pre_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic [31:0] pc;
  logic        pc_adef;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  int vec  = 0;
  int miss = 0;

  pre_if_stage #(.RESET_PC(32'h1c00_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allow_in     (fs_allow_in),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .to_fs_valid     (to_fs_valid),
    .pc              (pc),
    .pc_adef         (pc_adef),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
  );

  always #5 clk = ~clk;

  // Reset for two edges, release at a negedge with idle inputs.
  task automatic do_reset();
    reset = 1'b1; fs_allow_in = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fs_allow_in = 1'b1; br_taken = 1'b1; br_target = 32'h1c00_0300;
    @(negedge clk); #1;
    vec++; if (to_fs_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b want 0", to_fs_valid); end
    vec++; if (inst_sram_en !== 1'b0) begin miss++; $display("FAIL reset_en got %b want 0", inst_sram_en); end
    vec++; if (inst_sram_addr !== 32'h1c00_0000) begin miss++; $display("FAIL reset_addr got %h want 1c000000", inst_sram_addr); end
    vec++; if (pc !== 32'h1bff_fffc) begin miss++; $display("FAIL reset_pc got %h want 1bfffffc", pc); end
    vec++; if (pc_adef !== 1'b0) begin miss++; $display("FAIL reset_adef got %b want 0", pc_adef); end
    vec++; if (inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'h0) begin miss++; $display("FAIL reset_we_wdata got %h/%h want 0/0", inst_sram_we, inst_sram_wdata); end
    @(negedge clk);
  endtask

  task automatic test_sequential();
    logic [31:0] ea [4] = '{32'h1c00_0000, 32'h1c00_0004, 32'h1c00_0008, 32'h1c00_000c};
    logic [31:0] ep [4] = '{32'h1bff_fffc, 32'h1c00_0000, 32'h1c00_0004, 32'h1c00_0008};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++; if (inst_sram_addr !== ea[i] || pc !== ep[i]) begin miss++; $display("FAIL seq[%0d] addr/pc got %h/%h want %h/%h", i, inst_sram_addr, pc, ea[i], ep[i]); end
      vec++; if (to_fs_valid !== 1'b1 || inst_sram_en !== 1'b1) begin miss++; $display("FAIL seq_valid[%0d] got %b/%b want 1/1", i, to_fs_valid, inst_sram_en); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic        fs [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ea [6] = '{32'h1c00_0004, 32'h1c00_0008, 32'h1c00_0008, 32'h1c00_0008, 32'h1c00_0008, 32'h1c00_000c};
    logic [31:0] ep [6] = '{32'h1c00_0000, 32'h1c00_0004, 32'h1c00_0008, 32'h1c00_0008, 32'h1c00_0008, 32'h1c00_0008};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      fs_allow_in = fs[i]; #1;
      vec++; if (inst_sram_addr !== ea[i] || pc !== ep[i]) begin miss++; $display("FAIL stall[%0d] addr/pc got %h/%h want %h/%h", i, inst_sram_addr, pc, ea[i], ep[i]); end
      @(negedge clk);
    end
    #1;
    vec++; if (pc !== 32'h1c00_000c) begin miss++; $display("FAIL stall_release_pc got %h want 1c00000c", pc); end
  endtask

  task automatic test_branch();
    logic        br [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ea [3] = '{32'h1c00_0100, 32'h1c00_0104, 32'h1c00_0108};
    logic [31:0] ep [3] = '{32'h1bff_fffc, 32'h1c00_0100, 32'h1c00_0104};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      br_taken = br[i]; br_target = 32'h1c00_0100; #1;
      vec++; if (inst_sram_addr !== ea[i] || pc !== ep[i]) begin miss++; $display("FAIL branch[%0d] addr/pc got %h/%h want %h/%h", i, inst_sram_addr, pc, ea[i], ep[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_stall();
    logic        fs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        br [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ea [6] = '{32'h1bff_fffc, 32'h1bff_fffc, 32'h1bff_fffc, 32'h1c00_0200, 32'h1c00_0204, 32'h1c00_0208};
    logic [31:0] ep [6] = '{32'h1bff_fffc, 32'h1bff_fffc, 32'h1bff_fffc, 32'h1bff_fffc, 32'h1c00_0200, 32'h1c00_0204};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      fs_allow_in = fs[i]; br_taken = br[i]; br_target = br[i] ? 32'h1c00_0200 : 32'h0; #1;
      vec++; if (inst_sram_addr !== ea[i] || pc !== ep[i]) begin miss++; $display("FAIL br_stall[%0d] addr/pc got %h/%h want %h/%h", i, inst_sram_addr, pc, ea[i], ep[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic        fs [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        br [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] bt [7] = '{32'h1c00_0200, 32'h1c00_0300, 32'h0, 32'h1c00_0400, 32'h1c00_0500, 32'h0, 32'h0};
    logic [31:0] ea [7] = '{32'h1bff_fffc, 32'h1c00_0300, 32'h1c00_0304, 32'h1c00_0304, 32'h1c00_0304, 32'h1c00_0304, 32'h1c00_0500};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      fs_allow_in = fs[i]; br_taken = br[i]; br_target = bt[i]; #1;
      vec++; if (inst_sram_addr !== ea[i]) begin miss++; $display("FAIL b2b[%0d] addr got %h want %h", i, inst_sram_addr, ea[i]); end
      @(negedge clk);
    end
    #1;
    vec++; if (pc !== 32'h1c00_0500 || inst_sram_addr !== 32'h1c00_0504) begin miss++; $display("FAIL b2b_final pc/addr got %h/%h want 1c000500/1c000504", pc, inst_sram_addr); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    fs_allow_in = 1'b0; br_taken = 1'b1; br_target = 32'h1c00_0200;
    @(negedge clk);
    reset = 1'b1; br_taken = 1'b1; #1;
    vec++; if (to_fs_valid !== 1'b0 || inst_sram_en !== 1'b0 || inst_sram_addr !== 32'h1c00_0000) begin miss++; $display("FAIL rst_pend_during got %b/%b/%h want 0/0/1c000000", to_fs_valid, inst_sram_en, inst_sram_addr); end
    @(negedge clk);
    reset = 1'b0; br_taken = 1'b0; fs_allow_in = 1'b1; #1;
    vec++; if (inst_sram_addr !== 32'h1c00_0000 || pc !== 32'h1bff_fffc) begin miss++; $display("FAIL rst_pend_release addr/pc got %h/%h want 1c000000/1bfffffc", inst_sram_addr, pc); end
    @(negedge clk); #1;
    vec++; if (inst_sram_addr !== 32'h1c00_0004 || pc !== 32'h1c00_0000) begin miss++; $display("FAIL rst_pend_next addr/pc got %h/%h want 1c000004/1c000000", inst_sram_addr, pc); end
    @(negedge clk);
  endtask

  task automatic test_misalign_wrap();
    do_reset();
    br_taken = 1'b1; br_target = 32'h1c00_0102; #1;
    vec++; if (inst_sram_addr !== 32'h1c00_0100 || pc_adef !== 1'b0) begin miss++; $display("FAIL misalign_issue addr/adef got %h/%b want 1c000100/0", inst_sram_addr, pc_adef); end
    @(negedge clk);
    br_taken = 1'b0; #1;
    vec++; if (pc !== 32'h1c00_0102 || pc_adef !== 1'b1 || inst_sram_addr !== 32'h1c00_0104) begin miss++; $display("FAIL misalign_pc pc/adef/addr got %h/%b/%h want 1c000102/1/1c000104", pc, pc_adef, inst_sram_addr); end
    @(negedge clk);
    br_taken = 1'b1; br_target = 32'hffff_fffc; #1;
    vec++; if (inst_sram_addr !== 32'hffff_fffc) begin miss++; $display("FAIL wrap_issue addr got %h want fffffffc", inst_sram_addr); end
    @(negedge clk);
    br_taken = 1'b0; #1;
    vec++; if (pc !== 32'hffff_fffc || inst_sram_addr !== 32'h0) begin miss++; $display("FAIL wrap_seq pc/addr got %h/%h want fffffffc/00000000", pc, inst_sram_addr); end
    @(negedge clk); #1;
    vec++; if (pc !== 32'h0 || pc_adef !== 1'b0 || inst_sram_addr !== 32'h4) begin miss++; $display("FAIL wrap_next pc/adef/addr got %h/%b/%h want 0/0/4", pc, pc_adef, inst_sram_addr); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; fs_allow_in = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_back_to_back();
    test_reset_pending();
    test_misalign_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
